// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving three cores serialised access to one single-port RAM.
module ram_arbiter #(
  parameter int DATA_LEN    = 16,
  parameter int ADDRESS_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               req,
  input  logic [2:0]               we,
  input  logic [3*ADDRESS_LEN-1:0] addr,
  input  logic [3*DATA_LEN-1:0]    wdata,
  output logic [2:0]               ack,
  output logic [3*DATA_LEN-1:0]    rdata,
  output logic [2:0]               grant,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDRESS_LEN-1:0]   mem_addr,
  output logic [DATA_LEN-1:0]      mem_wdata,
  input  logic [DATA_LEN-1:0]      mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  state_t                   state_q, state_d;
  logic [1:0]               rr_ptr_q, rr_ptr_d, idx_q, idx_d, win;
  logic [2:0]               grant_q, grant_d;
  logic                     we_q, we_d;
  logic [ADDRESS_LEN-1:0]   addr_q, addr_d;
  logic [DATA_LEN-1:0]      wdata_q, wdata_d;
  logic [3*DATA_LEN-1:0]    rdata_q, rdata_d;
  // first requester at or above rr_ptr, wrapping mod 3
  always_comb
    win = rr_ptr_q == 2'd1 ? (req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd0) :
          rr_ptr_q == 2'd2 ? (req[2] ? 2'd2 : req[0] ? 2'd0 : 2'd1) :
                             (req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2);
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = ACCESS;
        idx_d   = win;
        grant_d = 3'b001 << win;
        we_d    = we[win];
        addr_d  = addr[win*ADDRESS_LEN +: ADDRESS_LEN];
        wdata_d = wdata[win*DATA_LEN +: DATA_LEN];
      end
      ACCESS: state_d = WAIT;
      WAIT: begin
        state_d = DONE;
        if (!we_q) rdata_d[idx_q*DATA_LEN +: DATA_LEN] = mem_rdata;
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      grant_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  assign ack       = state_q == DONE ? grant_q : 3'b000;
  assign grant     = grant_q;
  assign rdata     = rdata_q;
  assign mem_read  = state_q == ACCESS && !we_q;
  assign mem_write = state_q == ACCESS && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a behavioural registered-output RAM.
module tb_ram_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  req = '0, we = '0;
  logic [23:0] addr = '0;
  logic [47:0] wdata = '0;
  logic [2:0]  ack, grant;
  logic [47:0] rdata;
  logic        mem_read, mem_write;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata = '0;
  logic [15:0] mem [256];
  int          n_assert = 0, n_fail = 0;
  int          ack_at [3];
  logic [2:0]  seq [3];
  logic        bad;
  logic [2:0]  acc;

  ram_arbiter #(.DATA_LEN(16), .ADDRESS_LEN(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .grant(grant), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input int k, input logic w, input logic [7:0] a, input logic [15:0] d);
    logic [2:0] g;
    g = 3'b001 << k;
    req[k] = 1'b1;
    we[k] = w;
    addr[k*8 +: 8] = a;
    wdata[k*16 +: 16] = d;
    @(negedge clk);
    chk("txn_mem_write", mem_write, w);
    chk("txn_mem_read", mem_read, !w);
    chk("txn_mem_addr", mem_addr, a);
    chk("txn_grant", grant, g);
    if (w) chk("txn_mem_wdata", mem_wdata, d);
    @(negedge clk);
    chk("txn_wait_strobes", {mem_read, mem_write}, 2'b00);
    chk("txn_wait_ack", ack, 3'b000);
    @(negedge clk);
    chk("txn_ack", ack, g);
    req[k] = 1'b0;
    @(negedge clk);
    chk("txn_ack_pulse", ack, 3'b000);
    chk("txn_grant_clear", grant, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #2;
    chk("rst_ack", ack, 3'b000);
    chk("rst_grant", grant, 3'b000);
    chk("rst_rdata", rdata, 48'h0);
    chk("rst_strobes", {mem_read, mem_write}, 2'b00);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_grant", grant, 3'b000);
    chk("idle_strobes", {mem_read, mem_write}, 2'b00);

    do_txn(1, 1'b1, 8'd5, 16'hABCD);
    chk("wr_rdata_untouched", rdata, 48'h0);
    do_txn(2, 1'b0, 8'd5, 16'h0000);
    chk("rd_rdata2", rdata[47:32], 16'hABCD);
    chk("rd_rdata01", rdata[31:0], 32'h0);

    #1 rst = 1'b1;
    #1;
    chk("rst2_rdata", rdata, 48'h0);
    chk("rst2_mem_addr", mem_addr, 8'h00);
    chk("rst2_mem_wdata", mem_wdata, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 3; k++) ack_at[k] = 0;
    bad = 1'b0;
    we = 3'b000;
    addr = {8'd5, 8'd5, 8'd5};
    req = 3'b111;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (mem_read && mem_write) bad = 1'b1;
      for (int k = 0; k < 3; k++)
        if (ack[k]) begin
          ack_at[k] = c;
          req[k] = 1'b0;
        end
    end
    chk("cont_ack0_cycle", ack_at[0], 3);
    chk("cont_ack1_cycle", ack_at[1], 7);
    chk("cont_ack2_cycle", ack_at[2], 11);
    chk("cont_strobe_mutex", bad, 1'b0);
    chk("cont_rdata", rdata, 48'hABCD_ABCD_ABCD);
    req = 3'b000;
    @(negedge clk);

    req = 3'b101;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 3) seq[0] = ack;
      if (c == 7) begin
        seq[1] = ack;
        req[2] = 1'b0;
      end
      if (c == 11) seq[2] = ack;
    end
    req = 3'b000;
    chk("rr_first", seq[0], 3'b001);
    chk("rr_second", seq[1], 3'b100);
    chk("rr_third", seq[2], 3'b001);
    @(negedge clk);
    @(negedge clk);

    do_txn(1, 1'b1, 8'd23, 16'h5555);
    we[0] = 1'b1;
    addr[7:0] = 8'd23;
    wdata[15:0] = 16'h1234;
    req = 3'b001;
    @(negedge clk);
    chk("abort_write_on", mem_write, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("abort_write_drop", mem_write, 1'b0);
    chk("abort_grant", grant, 3'b000);
    req = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    acc = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acc |= ack;
    end
    chk("abort_no_ack", acc, 3'b000);
    we = 3'b000;
    addr[7:0] = 8'd23;
    addr[23:16] = 8'd23;
    req = 3'b101;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("abort_rr_from0", ack, 3'b001);
        req[0] = 1'b0;
      end
      if (c == 7) begin
        chk("abort_second", ack, 3'b100);
        req[2] = 1'b0;
      end
    end
    chk("abort_old_value0", rdata[15:0], 16'h5555);
    chk("abort_old_value2", rdata[47:32], 16'h5555);
    @(negedge clk);

    we[0] = 1'b1;
    addr[7:0] = 8'd40;
    wdata[15:0] = 16'h7777;
    req = 3'b001;
    @(negedge clk);
    addr[7:0] = 8'd41;
    wdata[15:0] = 16'h9999;
    #1;
    chk("stab_access_addr", mem_addr, 8'd40);
    chk("stab_access_wdata", mem_wdata, 16'h7777);
    chk("stab_access_write", mem_write, 1'b1);
    @(negedge clk);
    addr[7:0] = 8'd42;
    wdata[15:0] = 16'hEEEE;
    we[0] = 1'b0;
    @(negedge clk);
    chk("stab_ack", ack, 3'b001);
    req = 3'b000;
    @(negedge clk);
    do_txn(1, 1'b0, 8'd40, 16'h0000);
    chk("stab_readback", rdata[31:16], 16'h7777);
    do_txn(2, 1'b0, 8'd41, 16'h0000);
    chk("stab_no_stray", rdata[47:32], 16'h0000);
    chk("stab_core0_hold", rdata[15:0], 16'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter between the three processing cores and the single-port shared data RAM. Each core posts one read or write request at a time. The arbiter serialises the requests onto the one RAM port and returns an acknowledge, plus read data for reads, to the core it granted. It sits directly downstream of the three core instances and directly upstream of the RAM, replacing the XOR-combined read/write strobes with one owned, one-hot-safe memory port.

## Interface
Parameters:
- DATA_LEN, 16, width of one data word
- ADDRESS_LEN, 8, width of one RAM address

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  3  per-core request, bit k = core k
- we  in  3  per-core write enable, 1 = write, 0 = read; valid when req[k]
- addr  in  3*ADDRESS_LEN  packed addresses, core k at [k*ADDRESS_LEN +: ADDRESS_LEN]
- wdata  in  3*DATA_LEN  packed write data, core k at [k*DATA_LEN +: DATA_LEN]
- ack  out  3  one-cycle completion pulse to core k
- rdata  out  3*DATA_LEN  packed read data returned per core
- grant  out  3  one-hot owner of the RAM port, 0 when idle
- mem_read  out  1  RAM read strobe
- mem_write  out  1  RAM write strobe
- mem_addr  out  ADDRESS_LEN  RAM address
- mem_wdata  out  DATA_LEN  RAM write data
- mem_rdata  in  DATA_LEN  RAM read data; valid the cycle after mem_read (registered RAM output)

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE. Transitions are unconditional except from IDLE.
- IDLE: if req != 0, pick the winner by round-robin, starting from priority pointer rr_ptr (0..2) and searching upward mod 3. On the same edge, latch the winner's we, addr, and wdata into internal registers, set grant, and go to ACCESS. If req == 0, stay in IDLE.
- ACCESS: drive mem_addr and mem_wdata from the latched values. Assert mem_write if the latched we is 1, otherwise mem_read. Go to WAIT.
- WAIT: both strobes are 0. On a read, capture mem_rdata into the granted core's rdata slice at the end of this cycle. Go to DONE.
- DONE: ack[grant] = 1. Set rr_ptr = (granted index + 1) mod 3. Clear grant on exit. Return to IDLE.
- mem_read and mem_write are never high together and are high only in ACCESS.
- The rdata slice for core k changes only at the completion of a read from core k. It holds its value through other cores' traffic and through core k's own writes.
- Requester rule: a core holds req, we, addr, and wdata until it sees ack, then drops req in the following cycle. A req still high when the FSM returns to IDLE is treated as a new request.
- Inputs from non-granted cores are ignored while the FSM is outside IDLE. Changes to the granted core's inputs after the grant have no effect, because the values are latched.
- Idle outputs: mem_addr and mem_wdata hold their last values, and the strobes are 0.

## Timing
- Reset (async, immediate): state = IDLE, rr_ptr = 0, and ack, grant, rdata, mem_read, mem_write, mem_addr, and mem_wdata are all 0.
- Latency: with req sampled high in IDLE at edge E0, mem strobe is high in cycle E0..E1, and ack is high in cycle E2..E3. This is a fixed 3-cycle request-to-ack latency for both reads and writes.
- Throughput: one transaction per 4 cycles (IDLE, ACCESS, WAIT, DONE).
- Simultaneous requests: the lowest index at or above rr_ptr (mod 3) wins. The others wait with no loss of their request.
- Fairness: a core that keeps requesting waits at most 2 other transactions, i.e. at most 8 cycles plus its own 3.
- Reset mid-transaction: the access is aborted and no ack is issued. Strobes drop asynchronously, so a write whose ACCESS cycle is cut before its clock edge is not committed. rr_ptr returns to 0.

## Test plan
- Reset: assert rst mid-idle → every output reads 0, grant = 3'b000, and state remains IDLE after release.
- Write/read round trip: core 1 writes 16'hABCD to addr 8'd5 → mem_write = 1 with mem_addr = 5 for exactly one cycle, and ack[1] follows 3 cycles after the request. Core 2 then reads addr 5 → ack[2] follows after 3 cycles, and rdata[2] slice = 16'hABCD, while the core 0 and core 1 slices are unchanged.
- Three-way contention after reset: all req bits go high in the same cycle and stay high until each core's ack → grants in the order 0, 1, 2, with ack pulses 3, 7, and 11 cycles after the first sample. mem_read and mem_write are never high together.
- Round-robin fairness: core 0 re-requests immediately after every ack while core 2 requests once → the order is core 0, core 2, core 0, and core 2 is not starved.
- Reset during ACCESS of a write of 16'h1234 to addr 8'd23 → mem_write falls immediately, no ack is issued, a later read of addr 23 returns the old value, and the next arbitration starts from core 0.
- Stability: core 0 changes addr and wdata during WAIT → the RAM access uses the values latched at grant.
